// File: rtl/spi_xfer_sequencer.sv
// Sequences CS-framed SPI bursts from a TX byte FIFO into a single-CS SPI master
// and collects the returned bytes into a first-word-fall-through RX FIFO.
module spi_xfer_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int FIFO_DEPTH       = 16,
  localparam int LW = $clog2(MAX_BYTES_PER_CS + 1),
  localparam int FW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Wr_Full,
  output logic [FW-1:0] o_TX_Level,
  input  logic          i_Start,
  input  logic [LW-1:0] i_Len,
  output logic          o_Busy,
  output logic          o_Done,
  output logic          o_Err,
  output logic [7:0]    o_Rd_Byte,
  output logic          o_Rd_Valid,
  input  logic          i_Rd_En,
  output logic [LW-1:0] o_TX_Count,
  output logic [7:0]    o_TX_Byte,
  output logic          o_TX_DV,
  input  logic          i_TX_Ready,
  input  logic          i_RX_DV,
  input  logic [7:0]    i_RX_Byte,
  input  logic          i_CS_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] DEPTH_F = FW'(FIFO_DEPTH);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_BYTES_PER_CS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_DRAIN} state_t;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp_q, tx_rp_q;
  logic [FW-1:0] tx_lvl_q, tx_lvl_d;
  logic          tx_full_q;
  logic          tx_push, tx_pop;

  assign tx_push  = i_Wr_DV & ~tx_full_q;
  assign tx_lvl_d = tx_lvl_q + FW'(tx_push) - FW'(tx_pop);

  always_ff @(posedge i_Clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_lvl_q  <= '0;
      tx_full_q <= 1'b0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_lvl_q  <= tx_lvl_d;
      tx_full_q <= (tx_lvl_d == DEPTH_F);
    end
  end

  // RX FIFO; the head byte is kept in its own register so it resets cleanly
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp_q, rx_rp_q, rx_rp_nxt;
  logic [FW-1:0] rx_lvl_q, rx_lvl_d;
  logic [7:0]    rx_head_q, rx_head_d;
  logic          rx_valid_q;
  logic          rx_push, rx_pop;

  assign rx_push   = i_RX_DV & (rx_lvl_q != DEPTH_F);
  assign rx_pop    = i_Rd_En & rx_valid_q;
  assign rx_lvl_d  = rx_lvl_q + FW'(rx_push) - FW'(rx_pop);
  assign rx_rp_nxt = rx_rp_q + 1'b1;

  always_comb begin
    rx_head_d = rx_head_q;
    if (rx_pop) begin
      if (rx_lvl_q > FW'(1)) rx_head_d = rx_mem[rx_rp_nxt];
      else if (rx_push)      rx_head_d = i_RX_Byte;
    end else if (rx_lvl_q == '0 && rx_push) begin
      rx_head_d = i_RX_Byte;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= i_RX_Byte;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_lvl_q   <= '0;
      rx_head_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_nxt;
      rx_lvl_q   <= rx_lvl_d;
      rx_head_q  <= rx_head_d;
      rx_valid_q <= (rx_lvl_d != '0);
    end
  end

  // Burst control
  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d, sent_q, sent_d, recv_q, recv_d, tx_count_q, tx_count_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d, tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          start_ok;

  assign start_ok = (i_Len != '0) && (i_Len <= MAX_L) &&
                    (tx_lvl_q >= FW'(i_Len)) && ((DEPTH_F - rx_lvl_q) >= FW'(i_Len));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    sent_d     = sent_q;
    recv_d     = recv_q;
    tx_count_d = tx_count_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    tx_pop     = 1'b0;

    if (busy_q && i_RX_DV && recv_q != MAX_L) recv_d = recv_q + 1'b1;
    if (i_Start && !(state_q == S_IDLE && start_ok)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_Start && start_ok) begin
          state_d    = S_ISSUE;
          len_d      = i_Len;
          tx_count_d = i_Len;
          sent_d     = '0;
          recv_d     = '0;
        end
      end
      S_ISSUE: begin
        // DV is registered so the master's DV-gated ready never loops back combinationally
        if (i_TX_Ready && !tx_dv_q) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = tx_mem[tx_rp_q];
          tx_pop    = 1'b1;
          sent_d    = sent_q + 1'b1;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        state_d = (sent_q < len_q) ? S_ISSUE : S_DRAIN;
      end
      S_DRAIN: begin
        if (recv_q == len_q && i_CS_n) begin
          done_d     = 1'b1;
          tx_count_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      sent_q     <= '0;
      recv_q     <= '0;
      tx_count_q <= '0;
      tx_byte_q  <= '0;
      tx_dv_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sent_q     <= sent_d;
      recv_q     <= recv_d;
      tx_count_q <= tx_count_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_Wr_Full  = tx_full_q;
  assign o_TX_Level = tx_lvl_q;
  assign o_Busy     = busy_q;
  assign o_Done     = done_q;
  assign o_Err      = err_q;
  assign o_Rd_Byte  = rx_head_q;
  assign o_Rd_Valid = rx_valid_q;
  assign o_TX_Count = tx_count_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_TX_DV    = tx_dv_q;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer: a behavioural single-CS SPI master with MOSI looped
// to MISO, and a queue of expected RX bytes checked as the RX FIFO is drained.
module tb_spi_xfer_sequencer;
  localparam int LW = 2;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          wr_dv = 1'b0;
  logic [7:0]    wr_byte = '0;
  logic          wr_full;
  logic [FW-1:0] tx_level;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;
  logic [7:0]    rd_byte;
  logic          rd_valid;
  logic          rd_en = 1'b0;
  logic [LW-1:0] tx_count;
  logic [7:0]    tx_byte;
  logic          tx_dv, tx_ready, rx_dv, cs_n;
  logic [7:0]    rx_byte;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_xfer_sequencer #(.MAX_BYTES_PER_CS(2), .FIFO_DEPTH(16)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Wr_DV(wr_dv), .i_Wr_Byte(wr_byte),
    .o_Wr_Full(wr_full), .o_TX_Level(tx_level), .i_Start(start), .i_Len(len),
    .o_Busy(busy), .o_Done(done), .o_Err(err), .o_Rd_Byte(rd_byte),
    .o_Rd_Valid(rd_valid), .i_Rd_En(rd_en), .o_TX_Count(tx_count),
    .o_TX_Byte(tx_byte), .o_TX_DV(tx_dv), .i_TX_Ready(tx_ready),
    .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_CS_n(cs_n)
  );

  // Master model: 8 cycles per byte, ready between bytes of a burst, CS rises 3 cycles after last byte
  int         m_st, m_rem, m_tmr;
  logic       m_ready, m_cs_n, m_rx_dv;
  logic [7:0] m_rx_byte, m_sh;

  assign tx_ready = m_ready & ~tx_dv;
  assign rx_dv    = m_rx_dv;
  assign rx_byte  = m_rx_byte;
  assign cs_n     = m_cs_n;

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_st <= 0; m_rem <= 0; m_tmr <= 0; m_ready <= 1'b1; m_cs_n <= 1'b1;
      m_rx_dv <= 1'b0; m_rx_byte <= '0; m_sh <= '0;
    end else begin
      m_rx_dv <= 1'b0;
      case (m_st)
        0: if (tx_dv) begin
             m_cs_n <= 1'b0; m_rem <= int'(tx_count); m_sh <= tx_byte;
             m_tmr <= 8; m_ready <= 1'b0; m_st <= 1;
           end
        1: if (m_tmr > 1) m_tmr <= m_tmr - 1;
           else begin
             m_rx_dv <= 1'b1; m_rx_byte <= m_sh; m_rem <= m_rem - 1;
             if (m_rem <= 1) begin m_st <= 3; m_tmr <= 3; end
             else begin m_st <= 2; m_ready <= 1'b1; end
           end
        2: if (tx_dv) begin m_sh <= tx_byte; m_tmr <= 8; m_ready <= 1'b0; m_st <= 1; end
        default: if (m_tmr > 1) m_tmr <= m_tmr - 1;
                 else begin m_cs_n <= 1'b1; m_ready <= 1'b1; m_st <= 0; end
      endcase
    end
  end

  int   dv_cnt = 0, dv_long = 0, done_cnt = 0, err_cnt = 0, cs_falls = 0, rxdv_cnt = 0, proto_err = 0;
  logic dv_prev = 1'b0, cs_prev = 1'b1;

  always @(negedge clk) begin
    if (tx_dv) dv_cnt++;
    if (tx_dv && dv_prev) dv_long++;
    if (tx_dv && !(m_st == 0 || m_st == 2)) proto_err++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (!cs_n && cs_prev) cs_falls++;
    if (rx_dv) rxdv_cnt++;
    dv_prev = tx_dv;
    cs_prev = cs_n;
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    wr_dv = 1'b1; wr_byte = b;
    @(posedge clk); #1;
    wr_dv = 1'b0;
  endtask

  task automatic start_x(input int n);
    start = 1'b1; len = LW'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++;
    if (done_cnt == d0) $display("FAIL %s_done: no o_Done within %0d cycles", name, budget);
    else pass_cnt++;
  endtask

  task automatic drain_rx(input string name, input int n);
    logic [7:0] want;
    for (int i = 0; i < n; i++) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total_cnt++;
      if (rd_valid !== 1'b1 || rd_byte !== want)
        $display("FAIL %s_rx[%0d]: valid=%b byte=%02h, want valid=1 byte=%02h", name, i, rd_valid, rd_byte, want);
      else pass_cnt++;
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
    end
    total_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL %s_rx_empty: valid=%b want 0", name, rd_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    #1;
    total_cnt++;
    if ({wr_full, tx_level, busy, done, err, rd_byte, rd_valid, tx_count, tx_byte, tx_dv} !== '0)
      $display("FAIL reset_outputs: full=%b lvl=%0d busy=%b done=%b err=%b rd=%02h v=%b cnt=%0d txb=%02h dv=%b, want all 0",
               wr_full, tx_level, busy, done, err, rd_byte, rd_valid, tx_count, tx_byte, tx_dv);
    else pass_cnt++;
    clk_wait(3);
    rst_l = 1'b1;
    clk_wait(2);
    exp_q.delete();
  endtask

  task automatic test_basic();
    int d0 = dv_cnt, c0 = cs_falls, n0 = done_cnt;
    push_tx(8'hA5); push_tx(8'h3C);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    start_x(2);
    total_cnt++;
    if (busy !== 1'b1 || tx_count !== 2'd2 || err !== 1'b0)
      $display("FAIL basic_accept: busy=%b count=%0d err=%b, want 1 2 0", busy, tx_count, err);
    else pass_cnt++;
    wait_done("basic", 400);
    total_cnt++;
    if (dv_cnt - d0 != 2 || cs_falls - c0 != 1 || done_cnt - n0 != 1)
      $display("FAIL basic_counts: dv=%0d cs_low=%0d done=%0d, want 2 1 1", dv_cnt - d0, cs_falls - c0, done_cnt - n0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || tx_level !== 5'd0)
      $display("FAIL basic_idle: busy=%b level=%0d, want 0 0", busy, tx_level);
    else pass_cnt++;
    drain_rx("basic", 2);
  endtask

  task automatic test_short_len();
    int e0 = err_cnt, d0 = dv_cnt;
    push_tx(8'h77);
    start_x(2);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL short_err: err=%b want 1", err);
    else pass_cnt++;
    clk_wait(1);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL short_err_width: err=%b want 0", err);
    else pass_cnt++;
    clk_wait(30);
    total_cnt++;
    if (dv_cnt != d0 || busy !== 1'b0 || tx_level !== 5'd1 || err_cnt - e0 != 1)
      $display("FAIL short_nochange: dv=%0d busy=%b level=%0d errs=%0d, want 0 0 1 1", dv_cnt - d0, busy, tx_level, err_cnt - e0);
    else pass_cnt++;
    push_tx(8'h78);
    exp_q.push_back(8'h77); exp_q.push_back(8'h78);
    start_x(2);
    wait_done("short_followup", 400);
    drain_rx("short_followup", 2);
  endtask

  task automatic test_bad_len();
    int c0 = cs_falls, e0 = err_cnt;
    push_tx(8'h55);
    start_x(0);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL len0_err: err=%b want 1", err);
    else pass_cnt++;
    clk_wait(1);
    start_x(3);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL len3_err: err=%b want 1", err);
    else pass_cnt++;
    clk_wait(20);
    total_cnt++;
    if (cs_falls != c0 || err_cnt - e0 != 2 || tx_level !== 5'd1 || busy !== 1'b0)
      $display("FAIL badlen_nochange: cs_low=%0d errs=%0d level=%0d busy=%b, want 0 2 1 0", cs_falls - c0, err_cnt - e0, tx_level, busy);
    else pass_cnt++;
    exp_q.push_back(8'h55);
    start_x(1);
    wait_done("len1", 300);
    drain_rx("len1", 1);
  endtask

  task automatic test_fill();
    int d0;
    for (int i = 0; i <= 16; i++) begin
      push_tx(8'(i));
      total_cnt++;
      if (wr_full !== (i >= 15)) $display("FAIL fill_full[%0d]: full=%b want %b", i, wr_full, (i >= 15));
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_level !== 5'd16) $display("FAIL fill_level: level=%0d want 16", tx_level);
    else pass_cnt++;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    d0 = dv_cnt;
    for (int b = 0; b < 8; b++) begin
      start_x(2);
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL fill_start[%0d]: busy=%b want 1", b, busy);
      else pass_cnt++;
      if (b == 0) begin
        start_x(1);
        total_cnt++;
        if (err !== 1'b1 || busy !== 1'b1) $display("FAIL busy_start: err=%b busy=%b want 1 1", err, busy);
        else pass_cnt++;
      end
      wait_done("fill", 400);
    end
    total_cnt++;
    if (dv_cnt - d0 != 16 || tx_level !== 5'd0 || wr_full !== 1'b0)
      $display("FAIL fill_after: dv=%0d level=%0d full=%b, want 16 0 0", dv_cnt - d0, tx_level, wr_full);
    else pass_cnt++;
    push_tx(8'hAA); push_tx(8'hBB);
    start_x(2);
    total_cnt++;
    if (err !== 1'b1) $display("FAIL rxfull_err: err=%b want 1", err);
    else pass_cnt++;
    clk_wait(20);
    total_cnt++;
    if (busy !== 1'b0 || tx_level !== 5'd2) $display("FAIL rxfull_nochange: busy=%b level=%0d want 0 2", busy, tx_level);
    else pass_cnt++;
    drain_rx("fill", 16);
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    start_x(2);
    wait_done("fill_tail", 400);
    drain_rx("fill_tail", 2);
  endtask

  task automatic test_reset_mid();
    int r0, n;
    push_tx(8'h11); push_tx(8'h22);
    start_x(2);
    r0 = rxdv_cnt;
    n = 0;
    while (rxdv_cnt == r0 && n < 200) begin @(negedge clk); n++; end
    total_cnt++;
    if (rxdv_cnt == r0) $display("FAIL midreset_rxdv: no RX byte within 200 cycles");
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rd_valid !== 1'b1 || busy !== 1'b1) $display("FAIL midreset_pre: valid=%b busy=%b want 1 1", rd_valid, busy);
    else pass_cnt++;
    test_reset();
    test_basic();
  endtask

  task automatic test_concurrent();
    int n;
    push_tx(8'hC1);
    exp_q.push_back(8'hC1);
    start_x(1);
    wait_done("conc_pre", 300);
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_byte !== 8'hC1) $display("FAIL conc_pre_head: valid=%b byte=%02h want 1 c1", rd_valid, rd_byte);
    else pass_cnt++;
    push_tx(8'hB1); push_tx(8'hB2);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2);
    start = 1'b1; len = 2'd2;
    @(posedge clk); #1;
    start = 1'b0; wr_dv = 1'b1; wr_byte = 8'hB3;
    @(posedge clk); #1;
    wr_dv = 1'b0;
    total_cnt++;
    if (tx_dv !== 1'b1 || tx_byte !== 8'hB1 || tx_level !== 5'd2)
      $display("FAIL conc_push_pop: dv=%b byte=%02h level=%0d, want 1 b1 2", tx_dv, tx_byte, tx_level);
    else pass_cnt++;
    n = 0;
    while (rx_dv !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total_cnt++;
    if (rx_dv !== 1'b1) $display("FAIL conc_rxdv: no RX byte within 200 cycles");
    else pass_cnt++;
    total_cnt++;
    if (rd_byte !== exp_q[0]) $display("FAIL conc_rx_head: byte=%02h want %02h", rd_byte, exp_q[0]);
    else pass_cnt++;
    void'(exp_q.pop_front());
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b1 || rd_byte !== exp_q[0])
      $display("FAIL conc_rx_pushpop: valid=%b byte=%02h want 1 %02h", rd_valid, rd_byte, exp_q[0]);
    else pass_cnt++;
    wait_done("conc", 400);
    drain_rx("conc", 2);
    rd_en = 1'b1;
    clk_wait(1);
    rd_en = 1'b0;
    total_cnt++;
    if (rd_valid !== 1'b0) $display("FAIL conc_empty_rd: valid=%b want 0", rd_valid);
    else pass_cnt++;
    exp_q.push_back(8'hB3);
    start_x(1);
    wait_done("conc_tail", 300);
    drain_rx("conc_tail", 1);
    total_cnt++;
    if (tx_level !== 5'd0) $display("FAIL conc_tx_level: level=%0d want 0", tx_level);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_len();
    test_bad_len();
    test_fill();
    test_reset_mid();
    test_concurrent();
    total_cnt++;
    if (dv_long != 0 || proto_err != 0)
      $display("FAIL dv_protocol: long_pulses=%0d dv_while_master_busy=%0d, want 0 0", dv_long, proto_err);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish within 50000 cycles");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1);
  end

endmodule
